// File: rtl/decode_stage_hz.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_hz
// Description : RV32-subset decode stage with register file, immediate
//               generator, ID/EX register, stall/flush and load-use detection.
// Option      : DECODE_WB_BYPASS_EN - write-first register-file reads
// Revision    : 1.0
// ============================================================================
module decode_stage_hz #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic              valid_d,
  input  logic              stall_d,
  input  logic              flush_e,
  input  logic              reg_write_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic [XLEN-1:0]   result_w,
  output logic              load_use_stall,
  output logic              valid_e,
  output logic              reg_write_e,
  output logic              alu_src_e,
  output logic              mem_write_e,
  output logic              result_src_e,
  output logic              branch_e,
  output logic              illegal_e,
  output logic [2:0]        alu_control_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e
);

  localparam int         NREG    = 1 << REG_AW;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              alu_src;
    logic              mem_write;
    logic              result_src;
    logic              branch;
    logic              illegal;
    logic [2:0]        alu_control;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } idex_t;

  logic [XLEN-1:0]   rf_q [NREG];
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic [6:0]        opcode_d;
  logic [XLEN-1:0]   rd1_d, rd2_d, imm_i_d, imm_s_d, imm_b_d;
  logic [2:0]        alu_f3_d;
  logic              f3_bad_d;
  idex_t             dec_d, idex_d, idex_q;

  assign rs1_d    = instr_d[15 +: REG_AW];
  assign rs2_d    = instr_d[20 +: REG_AW];
  assign rd_d     = instr_d[7 +: REG_AW];
  assign opcode_d = instr_d[6:0];
  assign imm_i_d  = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
  assign imm_s_d  = {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
  assign imm_b_d  = {{(XLEN-12){instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (reg_write_w && rd_w != '0) begin
      rf_q[rd_w] <= result_w;
    end
  end

  always_comb begin
    rd1_d = (rs1_d == '0) ? '0 : rf_q[rs1_d];
    rd2_d = (rs2_d == '0) ? '0 : rf_q[rs2_d];
`ifdef DECODE_WB_BYPASS_EN
    // Write-first: same-cycle write-back wins over the stored value
    if (reg_write_w && rd_w != '0 && rd_w == rs1_d) rd1_d = result_w;
    if (reg_write_w && rd_w != '0 && rd_w == rs2_d) rd2_d = result_w;
`endif
  end

  always_comb begin
    alu_f3_d = ALU_ADD;
    f3_bad_d = 1'b0;
    case (instr_d[14:12])
      3'b000:  alu_f3_d = (opcode_d == OP_R && instr_d[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_f3_d = ALU_SLT;
      3'b110:  alu_f3_d = ALU_OR;
      3'b111:  alu_f3_d = ALU_AND;
      default: f3_bad_d = 1'b1;
    endcase
  end

  always_comb begin
    dec_d          = '0;
    dec_d.valid    = valid_d;
    dec_d.rd1      = rd1_d;
    dec_d.rd2      = rd2_d;
    dec_d.pc       = pc_d;
    dec_d.pc_plus4 = pc_plus4_d;
    dec_d.rs1      = rs1_d;
    dec_d.rs2      = rs2_d;
    dec_d.rd       = rd_d;
    if (valid_d) begin
      case (opcode_d)
        OP_LW: begin
          dec_d.reg_write  = 1'b1;
          dec_d.alu_src    = 1'b1;
          dec_d.result_src = 1'b1;
          dec_d.imm        = imm_i_d;
        end
        OP_SW: begin
          dec_d.mem_write = 1'b1;
          dec_d.alu_src   = 1'b1;
          dec_d.imm       = imm_s_d;
        end
        OP_R: begin
          dec_d.reg_write   = 1'b1;
          dec_d.alu_control = alu_f3_d;
          dec_d.illegal     = f3_bad_d;
        end
        OP_I: begin
          dec_d.reg_write   = 1'b1;
          dec_d.alu_src     = 1'b1;
          dec_d.alu_control = alu_f3_d;
          dec_d.illegal     = f3_bad_d;
          dec_d.imm         = imm_i_d;
        end
        OP_BEQ: begin
          dec_d.branch      = 1'b1;
          dec_d.alu_control = ALU_SUB;
          dec_d.imm         = imm_b_d;
        end
        default: dec_d.illegal = 1'b1;
      endcase
    end
  end

  assign load_use_stall = idex_q.valid & idex_q.result_src & (idex_q.rd != '0) & valid_d &
                          ((idex_q.rd == rs1_d) | (idex_q.rd == rs2_d));

  // Flush beats stall; a load-use hazard only inserts a bubble when not stalled
  always_comb begin
    idex_d = dec_d;
    if (flush_e)             idex_d = '0;
    else if (stall_d)        idex_d = idex_q;
    else if (load_use_stall) idex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign valid_e       = idex_q.valid;
  assign reg_write_e   = idex_q.reg_write;
  assign alu_src_e     = idex_q.alu_src;
  assign mem_write_e   = idex_q.mem_write;
  assign result_src_e  = idex_q.result_src;
  assign branch_e      = idex_q.branch;
  assign illegal_e     = idex_q.illegal;
  assign alu_control_e = idex_q.alu_control;
  assign rd1_e         = idex_q.rd1;
  assign rd2_e         = idex_q.rd2;
  assign imm_ext_e     = idex_q.imm;
  assign pc_e          = idex_q.pc;
  assign pc_plus4_e    = idex_q.pc_plus4;
  assign rs1_e         = idex_q.rs1;
  assign rs2_e         = idex_q.rs2;
  assign rd_e          = idex_q.rd;

endmodule
`default_nettype wire
